// File: rtl/probe_trigger_ctrl.sv
// Purpose: LogicProbe trigger sequencer (masked match x N, post-match delay) plus sample prescaler.
// Latency: trigger registered one cycle after the final match (dly=0) or dly cycles after it.
// Backpressure: none; every input is sampled every cycle and outputs are plain registered strobes.
module probe_trigger_ctrl #(
  parameter int WIDTH = 128,
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             disarm,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] match_val,
  input  logic [WIDTH-1:0] match_mask,
  input  logic [7:0]       occur,
  input  logic [DLY_W-1:0] delay,
  input  logic [7:0]       divide,
  output logic             trigger,
  output logic             sample,
  output logic [1:0]       state,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DELAY = 2'd2,
    S_FIRED = 2'd3
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] mval;
  logic [WIDTH-1:0] mmask;
  logic [7:0]       occ;
  logic [DLY_W-1:0] dly;
  logic [7:0]       mcnt;
  logic [DLY_W-1:0] dcnt;
  logic [7:0]       p;

  logic             hit;
  logic [7:0]       occ_last;
  logic             final_hit;
  logic             wrap;

  // An occurrence count of 0 behaves like 1, so the last match index is 0 in both cases.
  assign hit       = ((data ^ mval) & mmask) == '0;
  assign occ_last  = (occ == 8'd0) ? 8'd0 : occ - 8'd1;
  assign final_hit = hit && (mcnt == occ_last);
  assign wrap      = (p >= divide);
  assign state     = st;

  // Trigger search: disarm beats arm, arm beats any in-progress match or delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_IDLE;
      trigger <= 1'b0;
      done    <= 1'b0;
      mval    <= '0;
      mmask   <= '0;
      occ     <= '0;
      dly     <= '0;
      mcnt    <= '0;
      dcnt    <= '0;
    end else begin
      trigger <= 1'b0;
      if (disarm) begin
        st   <= S_IDLE;
        done <= 1'b0;
        mcnt <= '0;
        dcnt <= '0;
      end else if (arm) begin
        mval  <= match_val;
        mmask <= match_mask;
        occ   <= occur;
        dly   <= delay;
        mcnt  <= '0;
        dcnt  <= '0;
        done  <= 1'b0;
        st    <= S_ARMED;
      end else begin
        case (st)
          S_IDLE: begin
          end
          S_ARMED: begin
            if (hit) begin
              if (final_hit) begin
                mcnt <= '0;
                if (dly == '0) begin
                  trigger <= 1'b1;
                  done    <= 1'b1;
                  st      <= S_FIRED;
                end else begin
                  dcnt <= dly;
                  st   <= S_DELAY;
                end
              end else begin
                mcnt <= mcnt + 8'd1;
              end
            end
          end
          S_DELAY: begin
            // Loaded with dly on the final match; firing at 1 lands the pulse exactly dly edges later.
            if (dcnt == DLY_W'(1)) begin
              trigger <= 1'b1;
              done    <= 1'b1;
              dcnt    <= '0;
              st      <= S_FIRED;
            end else begin
              dcnt <= dcnt - DLY_W'(1);
            end
          end
          S_FIRED: begin
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  // Free-running decimating prescaler; divide is used live so lowering it below p wraps at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      p      <= 8'd0;
      sample <= 1'b0;
    end else begin
      sample <= wrap;
      p      <= wrap ? 8'd0 : p + 8'd1;
    end
  end

endmodule

// File: tb/tb_probe_trigger_ctrl.sv
// Scoreboard bench for probe_trigger_ctrl: directed scenarios then random traffic,
// expected outputs per edge come from an event-level reference model (absolute fire cycle).
module tb_probe_trigger_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         arm = 1'b0;
  logic         disarm = 1'b0;
  logic [127:0] data = '0;
  logic [127:0] match_val = '0;
  logic [127:0] match_mask = '0;
  logic [7:0]   occur = '0;
  logic [15:0]  delay = '0;
  logic [7:0]   divide = '0;
  logic         trigger;
  logic         sample;
  logic [1:0]   state;
  logic         done;

  probe_trigger_ctrl #(.WIDTH(128), .DLY_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .disarm     (disarm),
    .data       (data),
    .match_val  (match_val),
    .match_mask (match_mask),
    .occur      (occur),
    .delay      (delay),
    .divide     (divide),
    .trigger    (trigger),
    .sample     (sample),
    .state      (state),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       trig;
    logic       samp;
    logic [1:0] st;
    logic       dn;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: counts cycles and remembers the absolute cycle the trigger is due.
  logic [127:0] m_val, m_mask;
  int           m_occ, m_dly, m_hits, m_presc;
  bit           m_search, m_fired;
  longint       m_fire_at, m_cyc;

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] hitdata(input logic [127:0] v, input logic [127:0] m);
    return (v & m) | (rnd() & ~m);
  endfunction

  task automatic model_eval(output exp_t e);
    e = '0;
    if (reset) begin
      m_val = '0; m_mask = '0; m_occ = 0; m_dly = 0; m_hits = 0;
      m_search = 0; m_fired = 0; m_fire_at = -1; m_cyc = 0; m_presc = 0;
      return;
    end
    m_cyc++;
    e.samp  = (m_presc >= int'(divide));
    m_presc = e.samp ? 0 : m_presc + 1;
    if (disarm) begin
      m_search = 0; m_fired = 0; m_fire_at = -1;
    end else if (arm) begin
      m_val = match_val; m_mask = match_mask; m_occ = int'(occur); m_dly = int'(delay);
      m_search = 1; m_fired = 0; m_hits = 0; m_fire_at = -1;
    end else if (m_search) begin
      if (m_fire_at < 0 && ((data ^ m_val) & m_mask) == '0) begin
        m_hits++;
        if (m_hits >= ((m_occ == 0) ? 1 : m_occ)) m_fire_at = m_cyc + m_dly;
      end
      if (m_fire_at == m_cyc) begin
        e.trig = 1'b1; m_fired = 1; m_search = 0; m_fire_at = -1;
      end
    end
    e.dn = m_fired;
    e.st = m_fired ? 2'd3 : (!m_search ? 2'd0 : (m_fire_at >= 0 ? 2'd2 : 2'd1));
  endtask

  // Drive one edge's inputs, predict the result, and hand the prediction to the monitor.
  task automatic step(input bit rst, input bit a, input bit d, input logic [127:0] dat);
    exp_t e;
    reset = rst; arm = a; disarm = d; data = dat;
    model_eval(e);
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: compares the DUT outputs against the oldest prediction, away from the clock edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("trigger", int'(trigger), int'(e.trig));
      chk("sample",  int'(sample),  int'(e.samp));
      chk("state",   int'(state),   int'(e.st));
      chk("done",    int'(done),    int'(e.dn));
    end
  end

  initial begin
    int r;
    logic [127:0] dat;
    // Reset, then prescaler with divide=3, then switch to divide=0 when p=2.
    repeat (2) step(1, 0, 0, rnd());
    divide = 8'd3;
    repeat (14) step(0, 0, 0, rnd());
    divide = 8'd0;
    repeat (4) step(0, 0, 0, rnd());

    // Full-width match, occur=0, delay=0.
    match_mask = '1;
    match_val  = {rnd(), 32'h7119C0CD};
    occur = 8'd0; delay = 16'd0;
    step(0, 1, 0, rnd());
    repeat (8) step(0, 0, 0, rnd());
    step(0, 0, 0, match_val);
    repeat (4) step(0, 0, 0, match_val);

    // Low-byte mask, three hits, delay 5; later hits inside the delay are ignored.
    match_mask = 128'h00FF;
    match_val  = rnd();
    occur = 8'd3; delay = 16'd5;
    step(0, 1, 0, rnd());
    for (int i = 0; i < 22; i++) begin
      dat = hitdata(match_val, match_mask);
      if (!(i == 0 || i == 3 || i == 10 || i == 11)) dat = dat ^ 128'h1;
      step(0, 0, 0, dat);
    end

    // arm+disarm together in ARMED, then arm with the match already present.
    occur = 8'd1; delay = 16'd0;
    step(0, 1, 0, rnd() ^ 128'h1);
    step(0, 0, 0, hitdata(match_val, match_mask) ^ 128'h1);
    step(0, 1, 1, rnd());
    step(0, 1, 0, hitdata(match_val, match_mask));
    repeat (4) step(0, 0, 0, hitdata(match_val, match_mask));

    // Reset while in DELAY.
    occur = 8'd1; delay = 16'd6;
    step(0, 1, 0, rnd());
    step(0, 0, 0, hitdata(match_val, match_mask));
    repeat (3) step(0, 0, 0, rnd());
    step(1, 0, 0, rnd());
    repeat (8) step(0, 0, 0, rnd());

    // Trigger, then re-arm in FIRED with a new condition.
    occur = 8'd2; delay = 16'd1;
    step(0, 1, 0, rnd());
    repeat (6) step(0, 0, 0, hitdata(match_val, match_mask));
    match_mask = 128'hF0F0_0000;
    match_val  = rnd();
    occur = 8'd1; delay = 16'd2;
    step(0, 1, 0, rnd());
    repeat (3) step(0, 0, 0, hitdata(match_val, match_mask) ^ 128'h1000_0000);
    repeat (5) step(0, 0, 0, hitdata(match_val, match_mask));

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 299));
      if ($urandom_range(0, 49) == 0) divide = 8'($urandom_range(0, 6));
      if (r >= 1 && r <= 15) begin
        match_val  = rnd();
        match_mask = ($urandom_range(0, 7) == 0) ? '0 : (rnd() & rnd() & rnd());
        occur = 8'($urandom_range(0, 3));
        delay = 16'($urandom_range(0, 4));
      end
      dat = ($urandom_range(0, 1) == 1) ? hitdata(m_val, m_mask) : rnd();
      step(r == 0, r >= 1 && r <= 15, r >= 12 && r <= 20, dat);
    end

    step(0, 0, 0, '0);
    for (int k = 0; k < 5 && expq.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/probe_trigger_ctrl.md
# probe_trigger_ctrl

Trigger and sample sequencer for the LogicProbe capture core. It watches the probed data word and raises LogicProbe's `trigger` input as a single-cycle pulse after a programmable condition: a masked pattern match, repeated N times, then a programmable post-match delay. It also drives LogicProbe's `sample` input from a programmable decimating prescaler. It sits between the design under observation and LogicProbe, replacing hard-wired trigger/sample logic in test designs.

## Interface
- `WIDTH`, default 128: probed data width; must match the LogicProbe data width.
- `DLY_W`, default 16: width of the post-match delay counter.
- `clk` in 1: single system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `arm` in 1: level, sampled each cycle; latches the configuration and starts a trigger search.
- `disarm` in 1: abort the search and return to IDLE; has priority over `arm`.
- `data` in WIDTH: probed word; the same word that LogicProbe logs.
- `match_val` in WIDTH: compare value.
- `match_mask` in WIDTH: 1 = bit participates in the compare, 0 = don't care.
- `occur` in 8: number of matches required; 0 is treated as 1.
- `delay` in DLY_W: cycles between the final match and the trigger pulse.
- `divide` in 8: `sample` fires once every `divide`+1 cycles; not latched, used live.
- `trigger` out 1: registered one-cycle pulse to LogicProbe.
- `sample` out 1: registered sample strobe to LogicProbe.
- `state` out 2: current state; 0 IDLE, 1 ARMED, 2 DELAY, 3 FIRED.
- `done` out 1: high from the cycle the trigger fires until the next accepted arm, disarm or reset.

## Operation
- Reset values: `trigger`=0, `sample`=0, `done`=0, `state`=IDLE; all counters and latched configuration are cleared.
- The match condition `hit` is `((data ^ mval) & mmask) == 0`. It uses the latched values `mval`, `mmask`, `occ` and `dly`.
- Configuration is latched on any cycle where `arm`=1 and `disarm`=0, in any state. Latching clears the match counter, the delay counter and `done`, and sets the next state to ARMED. Re-arming while ARMED or DELAY restarts the search.
- `disarm`=1: next state is IDLE, `done` is cleared, counters are cleared. `trigger` does not fire that cycle.
- IDLE: waits for an arm.
- ARMED: on each cycle with `hit`, the match counter increments. The final match is the cycle where `hit` is true and the counter equals `occ`-1.
  - On the final match with `dly`=0: assert `trigger` next cycle and go to FIRED.
  - On the final match with `dly`≠0: load the delay counter with `dly` and go to DELAY.
- DELAY: the delay counter decrements each cycle; `data` is ignored. When the counter reaches 1, assert `trigger` next cycle and go to FIRED.
- FIRED: `trigger` is high only for the entry cycle; `done` stays high. The block holds in FIRED until arm, disarm or reset.
- Matches are counted on every cycle, independent of `sample`.
- An arm in the same cycle as a final match: the arm wins; no trigger fires and the search restarts.
- Prescaler `p` (8 bits), each cycle: if `p` ≥ `divide` then `p` becomes 0, otherwise `p` becomes `p`+1. `sample` is the registered value of (`p` ≥ `divide`).
  - The prescaler runs in all states and is unaffected by arm and disarm.
  - If `divide` is lowered below `p`, the prescaler wraps on the next cycle.

## Timing
- Cycle k is the k-th rising edge with `reset` low.
- `divide`=0: `sample`=1 from cycle 1 onward.
- `divide`=D: `sample` is high after edges D+1, 2(D+1), …, one cycle wide.
- Arm sampled at edge a: `state`=ARMED after edge a. Matches are counted from edge a+1 (the data present before edge a+1).
- Final match sampled at edge m:
  - `dly`=0: `trigger`=1 and `done`=1 after edge m, i.e. one cycle after the matching data.
  - `dly`=L: `trigger`=1 after edge m+L, exactly L cycles later; `state`=DELAY during edges m … m+L-1.
- `trigger` deasserts after the following edge.
- `reset` mid-operation: all outputs return to their reset values at the next edge. A pending trigger is discarded.

## Test plan
- Reset, then `divide`=3 held: `sample` pulses after cycles 4, 8, 12. Change to `divide`=0 when `p`=2: `sample`=1 every cycle after one wrap cycle.
- Mask = all ones, `match_val`=32'h7119C0CD in the low word, `occur`=0, `delay`=0, arm; present the value at cycle 10: exactly one `trigger` pulse after cycle 10; `done`=1 from then on; `state`=3.
- Mask = 16'h00FF in the low bits, `occur`=3, `delay`=5: three hits at cycles 20, 23, 30 (upper bits random) → `trigger` after cycle 35 only; a hit on cycle 31 has no effect.
- `arm` and `disarm` both high in ARMED: `state`=IDLE and `done`=0. Arm again with the match already present: the trigger fires one cycle after the first counted match.
- `reset` asserted in DELAY with 2 cycles of delay remaining: `trigger` never fires; all outputs are 0 the next cycle; `state`=IDLE.
- Re-arm in FIRED: `done` clears next cycle, counters restart, and a second trigger fires on the new condition.
